hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised decode-stage hazard unit for the pipelined MIPS core. It generalises per-operand forwarding selection to any number of register read ports and forwarding stages. It adds load-use stall detection and a sequential tracker for the multi-cycle multiply/divide unit, so reads of HI/LO stall or forward correctly. It sits in the decode stage, between the register file read ports and the forwarding muxes, and also drives the pipeline stall.

## Interface

Parameters:
- `NUM_READ`, 2: number of operand read ports evaluated in parallel.
- `NUM_FWD`, 3: number of forwarding stages; stage 0 is youngest (execute), stage `NUM_FWD-1` is oldest (writeback).
- `MUL_CYCLES`, 3: multiply latency in cycles; must be 2 or more.
- `DIV_CYCLES`, 32: divide latency in cycles; must be 2 or more.
- `SELW`, `$clog2(NUM_FWD+2)`: width of one forward select; derived, not overridden.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `rd_idx` in `NUM_READ*5`: register index per read port; port i occupies bits `[5i+4:5i]`.
- `rd_hilo` in `NUM_READ`: port i reads HI or LO (mfhi/mflo) instead of a GPR.
- `fwd_en` in `NUM_FWD`: stage k writes a GPR.
- `fwd_dst` in `NUM_FWD*5`: destination register index of stage k.
- `fwd_ready` in `NUM_FWD`: stage k's result value is available this cycle. It is 0 for a load still in flight.
- `md_start` in 1: a mul/div op is issued from execute this cycle.
- `md_is_div` in 1: qualifies `md_start`; 1 = divide, 0 = multiply.
- `md_cancel` in 1: pipeline flush; aborts any mul/div op in flight.
- `fwd_sel` out `NUM_READ*SELW`: forward select per port. 0 = register file / HI-LO register; k+1 = stage k; `NUM_FWD+1` = mul/div result bus.
- `stall_d` out 1: freeze fetch/decode and bubble execute.
- `md_busy` out 1: mul/div op in progress.
- `md_done` out 1: mul/div result valid on the result bus this cycle.
- `stall_cycles` out 32: count of cycles with `stall_d`=1.

## Operation

GPR port i (`rd_hilo[i]`=0):
- If `rd_idx`=0: `fwd_sel`=0, no stall contribution.
- Otherwise scan stages k=0 upward and take the first k with `fwd_en[k]` and `fwd_dst[k]==rd_idx`.
  - If that stage has `fwd_ready[k]`=1: `fwd_sel`=k+1.
  - If it has `fwd_ready[k]`=0: `fwd_sel`=k+1 and the port requests a stall.
- No match: `fwd_sel`=0.
- Only the youngest matching stage counts; an older ready match never overrides a younger not-ready match.

HI/LO port i (`rd_hilo[i]`=1):
- State BUSY: stall request, `fwd_sel`=0.
- State DONE: `fwd_sel`=`NUM_FWD+1`, no stall.
- State IDLE: `fwd_sel`=0.

`stall_d` is the OR of all port stall requests. All of the above is combinational.

Mul/div FSM (states IDLE, BUSY, DONE) with down-counter `cnt`:
- From any state, `md_cancel`=1 → IDLE. Cancel has priority over `md_start` in the same cycle.
- From any state, `md_start`=1 (and no cancel) → BUSY, with `cnt` loaded to `DIV_CYCLES-1` or `MUL_CYCLES-1` according to `md_is_div`. A start while BUSY or DONE restarts the unit; the new op supersedes the old one.
- BUSY, no start/cancel: if `cnt==1` → DONE, else `cnt` decrements.
- DONE, no start/cancel → IDLE. HI/LO are written to their register that edge, so IDLE reads them from the register.
- Outputs: `md_busy`=(state==BUSY), `md_done`=(state==DONE).

Stall counter: `stall_cycles` increments by 1 on each clock edge where `stall_d`=1. It saturates at 32'hFFFF_FFFF and does not wrap.

## Timing

- Reset (`resetn`=0, asynchronous): state=IDLE, `cnt`=0, `stall_cycles`=0. Hence `md_busy`=0 and `md_done`=0 immediately. `fwd_sel` and `stall_d` follow their inputs combinationally. Reset asserted mid-operation aborts the op with no `md_done`.
- `fwd_sel` and `stall_d` have zero-cycle latency from the inputs.
- `md_start` sampled high at edge t gives `md_busy`=1 in cycles t+1 through t+LAT-1 and `md_done`=1 in cycle t+LAT only, where LAT is `MUL_CYCLES` or `DIV_CYCLES`.
- A HI/LO read stalls during BUSY cycles. It forwards in the DONE cycle and reads the register from the following cycle on.
- `stall_cycles` shows the count one cycle after the stalled cycle.

## Test plan

- Reset released, all inputs 0 → `fwd_sel`=0 on all ports, `stall_d`=0, `md_busy`=0, `stall_cycles`=0.
- Port 0 reads r5; stage 0 writes r5 with ready=0 and stage 2 writes r5 with ready=1 → `fwd_sel[0]`=1, `stall_d`=1. Next cycle, with stage 0 ready → `stall_d`=0 and `stall_cycles`=1.
- Port 1 reads r0 while every stage writes r0 → `fwd_sel[1]`=0, `stall_d`=0. Port 1 reads r7 matched only by stage 2 with ready=1 → `fwd_sel[1]`=3.
- `md_start` with `md_is_div`=1 at edge 0, default parameters, port 0 mfhi held → `md_busy` and `stall_d`=1 in cycles 1–31. Cycle 32: `md_done`=1, `fwd_sel[0]`=4, `stall_d`=0. Cycle 33: `fwd_sel[0]`=0.
- Multiply started; at cycle 1 `md_start` (multiply) again; at cycle 2 `md_cancel` together with `md_start` → cancel wins, IDLE at cycle 3, `md_done` never asserted.
- Divide in progress with `cnt`=10; `resetn` pulsed low asynchronously between edges → `md_busy`=0 and `stall_cycles`=0 immediately, no `md_done` afterwards.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard bundle. It groups the operand read ports, the forwarding-stage
// status, the mul/div control and the hazard unit's results.
// The pipeline drives this bundle through the master modport.
// The hazard unit sits on the slave modport.
interface hazard_scoreboard_if #(
    parameter int NUM_READ = 2,
    parameter int NUM_FWD  = 3
);
    localparam int SELW = $clog2(NUM_FWD + 2);

    logic [NUM_READ*5-1:0]    rd_idx;
    logic [NUM_READ-1:0]      rd_hilo;
    logic [NUM_FWD-1:0]       fwd_en;
    logic [NUM_FWD*5-1:0]     fwd_dst;
    logic [NUM_FWD-1:0]       fwd_ready;
    logic                     md_start;
    logic                     md_is_div;
    logic                     md_cancel;
    logic [NUM_READ*SELW-1:0] fwd_sel;
    logic                     stall_d;
    logic                     md_busy;
    logic                     md_done;
    logic [31:0]              stall_cycles;

    modport master (
        output rd_idx, rd_hilo, fwd_en, fwd_dst, fwd_ready,
        output md_start, md_is_div, md_cancel,
        input  fwd_sel, stall_d, md_busy, md_done, stall_cycles
    );

    modport slave (
        input  rd_idx, rd_hilo, fwd_en, fwd_dst, fwd_ready,
        input  md_start, md_is_div, md_cancel,
        output fwd_sel, stall_d, md_busy, md_done, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit. It selects the forwarding source for each read port,
// raises the load-use / HI-LO stall, tracks the multi-cycle mul/div unit,
// and counts stalled cycles.
module hazard_scoreboard #(
    parameter int NUM_READ   = 2,
    parameter int NUM_FWD    = 3,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 32
) (
    input logic               clk,
    input logic               resetn,
    hazard_scoreboard_if.slave hz
);
    localparam int SELW = $clog2(NUM_FWD + 2);
    localparam int MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNTW = (MAXC > 2) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    md_state_t                state_r;
    md_state_t                state_next_s;
    logic [CNTW-1:0]          cnt_r;
    logic [CNTW-1:0]          cnt_next_s;
    logic                     busy_r;
    logic                     done_r;
    logic [31:0]              stall_cnt_r;
    logic [NUM_READ*SELW-1:0] fwd_sel_s;
    logic [NUM_READ-1:0]      stall_req_s;
    logic                     stall_s;

    // Per-port forward select and stall request; the youngest matching stage wins.
    always_comb begin
        fwd_sel_s   = '0;
        stall_req_s = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (hz.rd_hilo[i]) begin
                case (state_r)
                    MD_BUSY: stall_req_s[i] = 1'b1;
                    MD_DONE: fwd_sel_s[i*SELW +: SELW] = SELW'(NUM_FWD + 1);
                    default: stall_req_s[i] = 1'b0;
                endcase
            end else if (hz.rd_idx[i*5 +: 5] != 5'd0) begin
                // Walk oldest to youngest so a younger match overwrites an older one.
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (hz.fwd_en[k] && (hz.fwd_dst[k*5 +: 5] == hz.rd_idx[i*5 +: 5])) begin
                        fwd_sel_s[i*SELW +: SELW] = SELW'(k + 1);
                        stall_req_s[i]            = ~hz.fwd_ready[k];
                    end else begin
                        fwd_sel_s[i*SELW +: SELW] = fwd_sel_s[i*SELW +: SELW];
                    end
                end
            end else begin
                // r0 is hard-wired zero: never forwarded, never stalls.
                stall_req_s[i] = 1'b0;
            end
        end
        stall_s = |stall_req_s;
    end

    // Mul/div next state; a cancel beats a start, and a start restarts from any state.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (hz.md_cancel) begin
            state_next_s = MD_IDLE;
            cnt_next_s   = '0;
        end else if (hz.md_start) begin
            state_next_s = MD_BUSY;
            cnt_next_s   = hz.md_is_div ? CNTW'(DIV_CYCLES - 1) : CNTW'(MUL_CYCLES - 1);
        end else begin
            case (state_r)
                MD_BUSY: begin
                    if (cnt_r == CNTW'(1)) begin
                        state_next_s = MD_DONE;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s = cnt_r - CNTW'(1);
                    end
                end
                MD_DONE: state_next_s = MD_IDLE;
                MD_IDLE: state_next_s = MD_IDLE;
                default: begin
                    state_next_s = MD_IDLE;
                    cnt_next_s   = '0;
                end
            endcase
        end
    end

    // Mul/div state, countdown and registered busy/done flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= MD_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s == MD_BUSY);
            done_r  <= (state_next_s == MD_DONE);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign hz.fwd_sel      = fwd_sel_s;
    assign hz.stall_d      = stall_s;
    assign hz.md_busy      = busy_r;
    assign hz.md_done      = done_r;
    assign hz.stall_cycles = stall_cnt_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard with default parameters.
// Each cycle pushes its expected outputs to a queue, then pops and compares them
// at the falling edge.
module tb_hazard_scoreboard;
    localparam int NUM_READ = 2;
    localparam int NUM_FWD  = 3;
    localparam int SELW     = $clog2(NUM_FWD + 2);

    localparam int SIG_SEL0  = 0;
    localparam int SIG_SEL1  = 1;
    localparam int SIG_STALL = 2;
    localparam int SIG_BUSY  = 3;
    localparam int SIG_DONE  = 4;
    localparam int SIG_SCNT  = 5;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    logic  clk;
    logic  resetn;
    exp_t  sb_q[$];
    int    n_checks;
    int    n_fail;
    int    exp_scnt;

    hazard_scoreboard_if #(.NUM_READ(NUM_READ), .NUM_FWD(NUM_FWD)) bus ();

    hazard_scoreboard #(
        .NUM_READ(NUM_READ), .NUM_FWD(NUM_FWD), .MUL_CYCLES(3), .DIV_CYCLES(32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .hz     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            SIG_SEL0:  return 32'(bus.fwd_sel[0 +: SELW]);
            SIG_SEL1:  return 32'(bus.fwd_sel[SELW +: SELW]);
            SIG_STALL: return 32'(bus.stall_d);
            SIG_BUSY:  return 32'(bus.md_busy);
            SIG_DONE:  return 32'(bus.md_done);
            default:   return bus.stall_cycles;
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, actual(e.sig), e.exp);
        end
    endtask

    // Expect a full output set for the current cycle, compare at negedge, then advance.
    task automatic cycle_check(input string tag, input int sel0, input int sel1,
                               input bit stall, input bit busy, input bit done);
        push({tag, ".sel0"},  SIG_SEL0,  32'(sel0));
        push({tag, ".sel1"},  SIG_SEL1,  32'(sel1));
        push({tag, ".stall"}, SIG_STALL, 32'(stall));
        push({tag, ".busy"},  SIG_BUSY,  32'(busy));
        push({tag, ".done"},  SIG_DONE,  32'(done));
        push({tag, ".scnt"},  SIG_SCNT,  32'(exp_scnt));
        @(negedge clk);
        drain();
        if (stall) exp_scnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rd_idx    = '0;
        bus.rd_hilo   = '0;
        bus.fwd_en    = '0;
        bus.fwd_dst   = '0;
        bus.fwd_ready = '0;
        bus.md_start  = 1'b0;
        bus.md_is_div = 1'b0;
        bus.md_cancel = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_scnt = 0;
        resetn   = 1'b0;
        clear_inputs();

        // Held in reset across an edge.
        @(posedge clk);
        #1;
        push("rst.busy", SIG_BUSY, 32'd0);
        push("rst.scnt", SIG_SCNT, 32'd0);
        drain();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycle_check("idle", 0, 0, 1'b0, 1'b0, 1'b0);

        // Younger not-ready r5 beats older ready r5.
        bus.rd_idx    = {5'd0, 5'd5};
        bus.fwd_en    = 3'b101;
        bus.fwd_dst   = {5'd5, 5'd0, 5'd5};
        bus.fwd_ready = 3'b100;
        cycle_check("loaduse", 1, 0, 1'b1, 1'b0, 1'b0);
        bus.fwd_ready = 3'b101;
        cycle_check("loadrdy", 1, 0, 1'b0, 1'b0, 1'b0);

        // r0 never forwards even when every stage writes r0 (some not ready).
        bus.rd_idx    = {5'd0, 5'd1};
        bus.fwd_en    = 3'b111;
        bus.fwd_dst   = {5'd0, 5'd0, 5'd0};
        bus.fwd_ready = 3'b010;
        cycle_check("r0", 0, 0, 1'b0, 1'b0, 1'b0);

        // r7 matched only by stage 2; stage 1 also names r7 but is disabled.
        bus.rd_idx    = {5'd7, 5'd1};
        bus.fwd_en    = 3'b101;
        bus.fwd_dst   = {5'd7, 5'd7, 5'd3};
        bus.fwd_ready = 3'b100;
        cycle_check("r7st2", 0, 3, 1'b0, 1'b0, 1'b0);

        // Both ports match; port 1 hits not-ready stage 1, port 0 ready stage 0.
        bus.rd_idx    = {5'd9, 5'd4};
        bus.fwd_en    = 3'b011;
        bus.fwd_dst   = {5'd0, 5'd9, 5'd4};
        bus.fwd_ready = 3'b001;
        cycle_check("port1stall", 1, 2, 1'b1, 1'b0, 1'b0);

        // Divide with mfhi on port 0.
        clear_inputs();
        bus.rd_hilo   = 2'b01;
        bus.md_start  = 1'b1;
        bus.md_is_div = 1'b1;
        cycle_check("div.c0", 0, 0, 1'b0, 1'b0, 1'b0);
        bus.md_start  = 1'b0;
        for (int j = 1; j <= 31; j++) begin
            cycle_check($sformatf("div.c%0d", j), 0, 0, 1'b1, 1'b1, 1'b0);
        end
        cycle_check("div.c32", 4, 0, 1'b0, 1'b0, 1'b1);
        cycle_check("div.c33", 0, 0, 1'b0, 1'b0, 1'b0);

        // Plain multiply: busy cycles 1-2, done in cycle 3.
        bus.md_start  = 1'b1;
        bus.md_is_div = 1'b0;
        cycle_check("mul.c0", 0, 0, 1'b0, 1'b0, 1'b0);
        bus.md_start  = 1'b0;
        cycle_check("mul.c1", 0, 0, 1'b1, 1'b1, 1'b0);
        cycle_check("mul.c2", 0, 0, 1'b1, 1'b1, 1'b0);
        cycle_check("mul.c3", 4, 0, 1'b0, 1'b0, 1'b1);
        cycle_check("mul.c4", 0, 0, 1'b0, 1'b0, 1'b0);

        // Restart then cancel-with-start: cancel wins, no done ever.
        bus.md_start = 1'b1;
        cycle_check("can.c0", 0, 0, 1'b0, 1'b0, 1'b0);
        cycle_check("can.c1", 0, 0, 1'b1, 1'b1, 1'b0);
        bus.md_cancel = 1'b1;
        cycle_check("can.c2", 0, 0, 1'b1, 1'b1, 1'b0);
        bus.md_cancel = 1'b0;
        bus.md_start  = 1'b0;
        for (int j = 3; j <= 6; j++) begin
            cycle_check($sformatf("can.c%0d", j), 0, 0, 1'b0, 1'b0, 1'b0);
        end

        // Divide aborted by an asynchronous reset while cnt is 10 (cycle 22).
        bus.md_start  = 1'b1;
        bus.md_is_div = 1'b1;
        cycle_check("rdiv.c0", 0, 0, 1'b0, 1'b0, 1'b0);
        bus.md_start  = 1'b0;
        for (int j = 1; j <= 21; j++) begin
            cycle_check($sformatf("rdiv.c%0d", j), 0, 0, 1'b1, 1'b1, 1'b0);
        end
        #1;
        resetn = 1'b0;
        #1;
        push("arst.busy",  SIG_BUSY,  32'd0);
        push("arst.done",  SIG_DONE,  32'd0);
        push("arst.stall", SIG_STALL, 32'd0);
        push("arst.scnt",  SIG_SCNT,  32'd0);
        drain();
        exp_scnt = 0;
        @(negedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 16; j++) begin
            cycle_check($sformatf("post.c%0d", j), 0, 0, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
